vga_plot_writer: RTL and testbench
==================================

// Module: vga_plot_writer
// PURPOSE
// Downstream consumer of the sine-trace pixel generator. On start: optionally clears the
// 160x120 12-bit frame buffer to a background colour, then runs the generator for one sweep.
// Each (x, y, colour) sample is converted into a frame-buffer write, and the block pulses
// frame_done when the sweep is complete.
// PARAMETERS
// FB_W     160    frame width in pixels; x range 0..FB_W-1
// FB_H     120    frame height in rows; samples with y >= FB_H are clipped (not written)
// ROM_LAT  1      cycles from gen_x to a valid gen_y (synchronous sine ROM); range 1..3
// BG_COLOR 12'h000  colour written during the clear phase
// PORTS
// clk        in   1   system clock; all logic is on the rising edge
// resetn     in   1   asynchronous active-low reset
// start      in   1   one-cycle request for a new frame; ignored unless idle
// bg_color   in   12  background colour; overrides BG_COLOR when bg_sel=1
// bg_sel     in   1   selects bg_color instead of BG_COLOR; sampled on accepted start
// gen_x      in   8   generator column (CounterX)
// gen_y      in   8   generator row (sine ROM q); arrives ROM_LAT cycles after gen_x
// gen_color  in   12  generator colour; treated as constant per sweep
// gen_done   in   1   generator finished flag; high while gen_x==FB_W-1
// gen_enable out  1   advances the generator column
// gen_reset  out  1   active-high synchronous reset to the generator
// fb_addr    out  15  frame-buffer address = y*FB_W + x
// fb_data    out  12  frame-buffer write data
// fb_we      out  1   frame-buffer write strobe; one write per cycle
// busy       out  1   high in every state except IDLE
// frame_done out  1   one-cycle pulse on the last flush cycle
// BEHAVIOUR
// - Reset values: state=IDLE; all outputs = 0; internal counters = 0.
// - States and transitions:
//   IDLE  -> CLEAR on start (DRAW if clear is compiled out). Latches the background colour.
//   CLEAR: gen_reset=1. Writes one address per cycle, 0..FB_W*FB_H-1 (19199), with the
//          background colour; fb_we=1. After the write to the last address -> DRAW.
//   DRAW:  gen_enable=1. Each cycle, gen_x is pushed into a ROM_LAT-deep pipeline
//          together with a valid bit.
//          The cycle gen_done=1 is the last push; the next state is FLUSH and gen_enable
//          drops to 0 in that same transition. The generator wraps itself to 0.
//   FLUSH: lasts ROM_LAT+1 cycles to drain the pipeline and address stage; frame_done is
//          pulsed on the final cycle -> IDLE.
// - Address stage (registered): addr = (y<<7)+(y<<5)+x; 15-bit result, no overflow for
//   in-range inputs.
// - Latency: gen_x to fb_we is ROM_LAT+1 cycles. Exactly FB_W samples per sweep.
// - Clipping: y >= FB_H forces fb_we=0 for that sample; pipeline timing is unchanged.
// - start while busy: ignored, with no effect on the frame in progress.
// - resetn asserted mid-frame: immediate return to IDLE; the pipeline is flushed with no
//   further fb_we; frame_done is not pulsed.
// - start during the frame_done cycle: ignored; the next start is accepted from IDLE.
// CONFIGURATION
// VGA_PLOT_CLEAR_EN defined: the CLEAR phase runs as described above.
// Not defined: IDLE->DRAW directly, gen_reset is pulsed for one cycle in IDLE on start,
//   and the bg_* inputs are unused.
// STRUCTURE
// - Package vga_plot_pkg: FB_W/FB_H defaults, FB_DEPTH=19200, ADDR_W=15, COLOR_W=12,
//   and the state enum {IDLE, CLEAR, DRAW, FLUSH}.
// - Sub-module vga_addr_calc: registered y*FB_W+x with the clip flag; carries data and
//   we alongside the address.
// - Top level: the FSM, the clear counter, the ROM_LAT alignment shift register, and
//   frame_done generation.
// TESTING
// 1 Reset: resetn=0 mid-clock -> all outputs 0 asynchronously; state IDLE after release.
// 2 Clear (CLEAR_EN): start with bg_sel=1, bg_color=12'h00F -> 19200 writes at 0..19199,
//   data 12'h00F, then DRAW.
// 3 Draw with a stub ROM (ROM_LAT=1, y=x%120): 160 writes; x=5 -> addr 805; x=130, y=10
//   -> addr 1730; data 12'hF00; frame_done once.
// 4 Clip: stub returns y=200 for x=50..59 -> exactly 150 writes; no write with addr>=19200.
// 5 Start while busy: second start in DRAW -> write count and frame_done count unchanged.
// 6 Reset mid-DRAW at x=80 -> fb_we=0 from reset onward; no frame_done; next start gives a
//   full frame.

Source files
------------

// File: rtl/vga_plot_pkg.sv
// vga_plot_pkg: frame-buffer geometry, bus widths and FSM state encoding for vga_plot_writer
package vga_plot_pkg;
  localparam int FB_W = 160;
  localparam int FB_H = 120;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int ADDR_W = 15;
  localparam int COLOR_W = 12;
  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, FLUSH} state_t;
endpackage

// File: rtl/vga_addr_calc.sv
// vga_addr_calc: registered y*FB_W+x address stage with clipping of rows y >= FB_H
// ports: x_in/y_in/data_in/valid_in sample in; addr/data/we registered frame-buffer write out
module vga_addr_calc import vga_plot_pkg::*; #(
  parameter int FB_W = vga_plot_pkg::FB_W,
  parameter int FB_H = vga_plot_pkg::FB_H
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [7:0]         x_in,
  input  logic [7:0]         y_in,
  input  logic [COLOR_W-1:0] data_in,
  input  logic               valid_in,
  output logic [ADDR_W-1:0]  addr,
  output logic [COLOR_W-1:0] data,
  output logic               we
);
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [COLOR_W-1:0] data_d, data_q;
  logic we_d, we_q;
  always_comb begin
    addr_d = ADDR_W'(y_in) * ADDR_W'(FB_W) + ADDR_W'(x_in);
    data_d = data_in;
    we_d = valid_in && y_in < 8'(FB_H);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      addr_q <= '0;
      data_q <= '0;
      we_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      we_q <= we_d;
    end
  assign addr = addr_q;
  assign data = data_q;
  assign we = we_q;
endmodule

// File: rtl/vga_plot_writer.sv
// vga_plot_writer: turns one generator sweep into frame-buffer writes, optionally clearing first
// ports: start/bg_* request side; gen_* sine-trace generator handshake; fb_* write port;
//        busy/frame_done status. Optional clear phase: define VGA_PLOT_CLEAR_EN.
module vga_plot_writer import vga_plot_pkg::*; #(
  parameter int FB_W = vga_plot_pkg::FB_W,
  parameter int FB_H = vga_plot_pkg::FB_H,
  parameter int ROM_LAT = 1,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [COLOR_W-1:0] bg_color,
  input  logic               bg_sel,
  input  logic [7:0]         gen_x,
  input  logic [7:0]         gen_y,
  input  logic [COLOR_W-1:0] gen_color,
  input  logic               gen_done,
  output logic               gen_enable,
  output logic               gen_reset,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               fb_we,
  output logic               busy,
  output logic               frame_done
);
  state_t state_q, state_d;
  logic [1:0] fl_q, fl_d;
  logic [ROM_LAT-1:0][7:0] px_q, px_d;
  logic [ROM_LAT-1:0] pv_q, pv_d;
  logic [ADDR_W-1:0] a_addr;
  logic [COLOR_W-1:0] a_data;
  logic a_we;
`ifdef VGA_PLOT_CLEAR_EN
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic [COLOR_W-1:0] bg_q, bg_d;
`endif
  always_comb begin
    state_d = state_q;
    fl_d = fl_q;
    // shift in the column each cycle so it lines up with the ROM row ROM_LAT cycles later
    px_d = (ROM_LAT*8)'({px_q, gen_x});
    pv_d = ROM_LAT'({pv_q, state_q == DRAW});
`ifdef VGA_PLOT_CLEAR_EN
    clr_d = clr_q;
    bg_d = bg_q;
`endif
    case (state_q)
      IDLE: if (start) begin
`ifdef VGA_PLOT_CLEAR_EN
        state_d = CLEAR;
        clr_d = '0;
        bg_d = bg_sel ? bg_color : BG_COLOR;
`else
        state_d = DRAW;
`endif
      end
`ifdef VGA_PLOT_CLEAR_EN
      CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == ADDR_W'(FB_W * FB_H - 1)) begin
          state_d = DRAW;
          clr_d = '0;
        end
      end
`endif
      DRAW: if (gen_done) begin
        state_d = FLUSH;
        fl_d = '0;
      end
      FLUSH: begin
        fl_d = fl_q + 1'b1;
        if (fl_q == 2'(ROM_LAT)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      fl_q <= '0;
      px_q <= '0;
      pv_q <= '0;
`ifdef VGA_PLOT_CLEAR_EN
      clr_q <= '0;
      bg_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      fl_q <= fl_d;
      px_q <= px_d;
      pv_q <= pv_d;
`ifdef VGA_PLOT_CLEAR_EN
      clr_q <= clr_d;
      bg_q <= bg_d;
`endif
    end
  vga_addr_calc #(.FB_W(FB_W), .FB_H(FB_H)) u_addr (
    .clk(clk),
    .resetn(resetn),
    .x_in(px_q[ROM_LAT-1]),
    .y_in(gen_y),
    .data_in(gen_color),
    .valid_in(pv_q[ROM_LAT-1]),
    .addr(a_addr),
    .data(a_data),
    .we(a_we)
  );
  assign busy = state_q != IDLE;
  assign gen_enable = state_q == DRAW;
  // the last flush cycle coincides with the final sample leaving the address stage
  assign frame_done = state_q == FLUSH && fl_q == 2'(ROM_LAT);
`ifdef VGA_PLOT_CLEAR_EN
  // the pipeline is empty throughout CLEAR, so the clear writes simply take over the port
  assign gen_reset = state_q == CLEAR;
  assign fb_addr = gen_reset ? clr_q : a_addr;
  assign fb_data = gen_reset ? bg_q : a_data;
  assign fb_we = gen_reset | a_we;
`else
  logic unused_bg;
  assign unused_bg = ^{bg_color, bg_sel, BG_COLOR};
  assign gen_reset = state_q == IDLE && start;
  assign fb_addr = a_addr;
  assign fb_data = a_data;
  assign fb_we = a_we;
`endif
endmodule

// File: tb/tb_vga_plot_writer.sv
// tb_vga_plot_writer: stub generator/ROM, cycle-accurate write schedule model and directed frames
module tb_vga_plot_writer;
  logic clk = 0, resetn = 0, start = 0, bg_sel = 1, clip_mode = 0, gen_done;
  logic [11:0] bg_color = 12'h00F, fb_data;
  logic [7:0] gx = 0, gy = 0;
  logic gen_enable, gen_reset, fb_we, busy, frame_done;
  logic [14:0] fb_addr;
`ifdef VGA_PLOT_CLEAR_EN
  localparam int OFF = 19200;
`else
  localparam int OFF = 0;
`endif
  localparam int LAST = OFF + 162;
  int cyc = 0, n_start = 0, checks = 0, fails = 0;
  int draw_wr = 0, dones = 0, bad_addr = 0, n805 = 0, n1730 = 0;
  bit active = 0;
  vga_plot_writer dut (
    .clk(clk), .resetn(resetn), .start(start), .bg_color(bg_color), .bg_sel(bg_sel),
    .gen_x(gx), .gen_y(gy), .gen_color(12'hF00), .gen_done(gen_done),
    .gen_enable(gen_enable), .gen_reset(gen_reset), .fb_addr(fb_addr), .fb_data(fb_data),
    .fb_we(fb_we), .busy(busy), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int ystub(int x, bit clip);
    return (clip && x >= 50 && x <= 59) ? 200 : x % 120;
  endfunction
  assign gen_done = gx == 8'd159;
  always @(posedge clk) begin
    if (gen_reset) gx <= 0;
    else if (gen_enable) gx <= gx == 8'd159 ? 8'd0 : gx + 8'd1;
    gy <= 8'(ystub(int'(gx), clip_mode));
  end
  // frame accepted at cycle n: clear writes at n+1..n+OFF, sample x enabled at n+OFF+1+x,
  // written at n+OFF+3+x, frame_done with the last write
  always @(negedge clk) begin
    int rel, x, y;
    logic eb, eg, ew, ed;
    logic [14:0] ea;
    logic [11:0] edat;
    rel = cyc - n_start;
    {eb, eg, ew, ed, ea, edat} = '0;
    if (active && rel <= LAST) begin
      eb = rel >= 1;
      eg = rel >= OFF + 1 && rel <= OFF + 160;
      if (rel >= 1 && rel <= OFF) begin
        ew = 1; ea = 15'(rel - 1); edat = 12'h00F;
      end
      if (rel >= OFF + 3) begin
        x = rel - OFF - 3;
        y = ystub(x, clip_mode);
        if (y < 120) begin
          ew = 1; ea = 15'(y * 160 + x); edat = 12'hF00;
        end
      end
      ed = rel == LAST;
    end
    checks++;
    if ({busy, gen_enable, fb_we, frame_done} !== {eb, eg, ew, ed} ||
        (ew && (fb_addr !== ea || fb_data !== edat))) begin
      fails++;
      $display("FAIL cycle %0d: busy/en/we/done=%b%b%b%b addr=%0d data=%h, required %b%b%b%b addr=%0d data=%h",
               cyc, busy, gen_enable, fb_we, frame_done, fb_addr, fb_data, eb, eg, ew, ed, ea, edat);
    end
    if (fb_we === 1'b1) begin
      if (fb_data == 12'hF00) draw_wr++;
      if (fb_addr >= 15'd19200) bad_addr++;
      if (fb_addr == 15'd805 && fb_data == 12'hF00) n805++;
      if (fb_addr == 15'd1730 && fb_data == 12'hF00) n1730++;
    end
    if (frame_done === 1'b1) dones++;
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic pulse_start();
    tick();
    start = 1;
    if (!(active && cyc - n_start <= LAST)) begin
      n_start = cyc;
      active = 1;
    end
    tick();
    start = 0;
  endtask
  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask
  initial begin
    int w0, d0;
    #1;
    check("reset_outputs", int'({busy, gen_enable, gen_reset, fb_we, frame_done, fb_addr, fb_data}), 0);
    repeat (3) tick();
    resetn = 1;
    tick();
    w0 = draw_wr; d0 = dones;
    pulse_start();
    repeat (OFF + 50) tick();
    pulse_start();
    while (cyc - n_start < LAST - 1) tick();
    pulse_start();
    repeat (10) tick();
    check("frameA_writes", draw_wr - w0, 160);
    check("frameA_done", dones - d0, 1);
    check("x5_addr805", n805, 1);
    check("x130_addr1730", n1730, 1);
    check("idle_after_done_start", int'(busy), 0);
    clip_mode = 1;
    w0 = draw_wr; d0 = dones;
    pulse_start();
    repeat (LAST + 5) tick();
    check("clip_writes", draw_wr - w0, 150);
    check("clip_done", dones - d0, 1);
    check("clip_no_oob", bad_addr, 0);
    clip_mode = 0;
    w0 = draw_wr; d0 = dones;
    pulse_start();
    while (cyc - n_start < OFF + 81) tick();
    resetn = 0;
    active = 0;
    #1;
    check("midframe_reset_outputs", int'({busy, gen_enable, gen_reset, fb_we, frame_done, fb_addr, fb_data}), 0);
    repeat (3) tick();
    resetn = 1;
    repeat (LAST) tick();
    check("aborted_writes", draw_wr - w0, 78);
    check("aborted_no_done", dones - d0, 0);
    w0 = draw_wr; d0 = dones;
    pulse_start();
    repeat (LAST + 5) tick();
    check("after_reset_writes", draw_wr - w0, 160);
    check("after_reset_done", dones - d0, 1);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
